// File: rtl/axis_tester_pkg.sv
// axis_tester_pkg
//   Shared types and helpers for the AXI-Stream loopback tester.
//   state_t        : top-level run sequencing (IDLE -> RUN -> DONE -> IDLE)
//   strb_all_ones  : builds an all-ones byte strobe of a given width
//   ERR_*          : bit positions of the per-beat error-cause vector
package axis_tester_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STRB_MAX = 128;

    localparam int ERR_DATA   = 0;
    localparam int ERR_STRB   = 1;
    localparam int ERR_LAST   = 2;
    localparam int ERR_CAUSES = 3;

    // Callers cast the result down to their own strobe width.
    function automatic logic [STRB_MAX-1:0] strb_all_ones(input int width);
        logic [STRB_MAX-1:0] mask;
        mask = '0;
        for (int i = 0; i < STRB_MAX; i++) begin
            if (i < width) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_pattern_checker.sv
// axis_pattern_checker
//   Receive half of the loopback tester. Accepts returned beats, compares each
//   against seed+index, counts bad beats and watches for an idle timeout.
//   Ports:
//     clk, reset           clock and synchronous active-high reset
//     clear                start command seen in IDLE: clear err_count/timeout
//     run_start            run is starting: rearm index, idle counter, tready
//     run                  top FSM is in RUN
//     len, seed            latched packet length and first data word
//     tdata/tstrb/tvalid/tlast/tready   returned AXI-Stream slave interface
//     err_count            saturating count of bad beats in the run
//     timeout              run aborted because nothing arrived for TIMEOUT cycles
//     run_end              this cycle closes the run (last beat or timeout)
//     run_clean            the run closing now has no errors and no timeout
module axis_pattern_checker
    import axis_tester_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      run_start,
    input  logic                      run,
    input  logic [LEN_WIDTH-1:0]      len,
    input  logic [DATA_WIDTH-1:0]     seed,
    input  logic [DATA_WIDTH-1:0]     tdata,
    input  logic [DATA_WIDTH/8-1:0]   tstrb,
    input  logic                      tvalid,
    input  logic                      tlast,
    output logic                      tready,
    output logic [LEN_WIDTH-1:0]      err_count,
    output logic                      timeout,
    output logic                      run_end,
    output logic                      run_clean
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [STRB_W-1:0] STRB_ONES = STRB_W'(strb_all_ones(STRB_W));

    logic [LEN_WIDTH-1:0]  rx_idx;
    logic [IDLE_W-1:0]     idle_cnt;
    logic                  accept;
    logic                  last_beat;
    logic                  beat_err;
    logic                  timeout_hit;
    logic [ERR_CAUSES-1:0] cause;

    // Several causes may apply to one beat, but a beat counts as one error.
    always_comb begin
        accept           = tready && tvalid;
        last_beat        = (rx_idx == len - LEN_WIDTH'(1));
        cause            = '0;
        cause[ERR_DATA]  = (tdata != seed + DATA_WIDTH'(rx_idx));
        cause[ERR_STRB]  = (tstrb != STRB_ONES);
        cause[ERR_LAST]  = (tlast != last_beat);
        beat_err         = accept && (cause != '0);
        timeout_hit      = run && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
        run_end          = (accept && last_beat) || timeout_hit;
        run_clean        = !timeout_hit && !beat_err && (err_count == '0);
    end

    // tready is registered: raised as the run starts, dropped once the last
    // beat is taken or the run times out.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_idx    <= '0;
            idle_cnt  <= '0;
            tready    <= 1'b0;
            err_count <= '0;
            timeout   <= 1'b0;
        end else begin
            if (clear) begin
                err_count <= '0;
                timeout   <= 1'b0;
            end
            if (run_start) begin
                rx_idx   <= '0;
                idle_cnt <= '0;
                tready   <= 1'b1;
            end else if (run) begin
                if (accept) begin
                    rx_idx   <= rx_idx + LEN_WIDTH'(1);
                    idle_cnt <= '0;
                    if (last_beat) tready <= 1'b0;
                    if (beat_err && (err_count != '1)) err_count <= err_count + LEN_WIDTH'(1);
                end else if (timeout_hit) begin
                    timeout <= 1'b1;
                    tready  <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/axis_loopback_tester.sv
// axis_loopback_tester
//   Generates one incrementing-pattern packet on m01 and checks the copy that
//   comes back on s01. Holds the run FSM and the transmit generator; receive
//   checking lives in axis_pattern_checker.
//   Ports:
//     axis_aclk, axis_reset      clock and synchronous active-high reset
//     start, pkt_len, seed       run command (pkt_len==0 is rejected)
//     m01_axis_*                 generated stream (master)
//     s01_axis_*                 returned stream (slave)
//     busy, done, pass, timeout, err_count   run status
module axis_loopback_tester
    import axis_tester_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int TIMEOUT    = 1024
) (
    input  logic                    axis_aclk,
    input  logic                    axis_reset,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    input  logic                    m01_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [LEN_WIDTH-1:0]    err_count
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [STRB_W-1:0] STRB_ONES = STRB_W'(strb_all_ones(STRB_W));

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [LEN_WIDTH-1:0]  tx_idx;
    logic                  start_cmd;
    logic                  run_start;
    logic                  run_end;
    logic                  run_clean;

    always_comb begin
        start_cmd = (state == IDLE) && start;
        run_start = start_cmd && (pkt_len != '0);
    end

    axis_pattern_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) u_checker (
        .clk       (axis_aclk),
        .reset     (axis_reset),
        .clear     (start_cmd),
        .run_start (run_start),
        .run       (state == RUN),
        .len       (len_q),
        .seed      (seed_q),
        .tdata     (s01_axis_tdata),
        .tstrb     (s01_axis_tstrb),
        .tvalid    (s01_axis_tvalid),
        .tlast     (s01_axis_tlast),
        .tready    (s01_axis_tready),
        .err_count (err_count),
        .timeout   (timeout),
        .run_end   (run_end),
        .run_clean (run_clean)
    );

    // The first beat is preloaded as the run starts so tvalid rises one cycle
    // after start. tlast is precomputed one beat ahead (tx_idx+2 == len means
    // the beat about to be presented is the final one). Ending the run wins
    // over the TX handshake, so a timeout drops tvalid even with beats left.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state           <= IDLE;
            len_q           <= '0;
            seed_q          <= '0;
            tx_idx          <= '0;
            m01_axis_tdata  <= '0;
            m01_axis_tstrb  <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tlast  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pass <= 1'b0;
                        if (pkt_len != '0) begin
                            state           <= RUN;
                            busy            <= 1'b1;
                            len_q           <= pkt_len;
                            seed_q          <= seed;
                            tx_idx          <= '0;
                            m01_axis_tdata  <= seed;
                            m01_axis_tstrb  <= STRB_ONES;
                            m01_axis_tvalid <= 1'b1;
                            m01_axis_tlast  <= (pkt_len == LEN_WIDTH'(1));
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (run_end) begin
                        state           <= DONE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        pass            <= run_clean;
                        m01_axis_tvalid <= 1'b0;
                        m01_axis_tstrb  <= '0;
                        m01_axis_tlast  <= 1'b0;
                    end else if (m01_axis_tvalid && m01_axis_tready) begin
                        tx_idx <= tx_idx + LEN_WIDTH'(1);
                        if (m01_axis_tlast) begin
                            m01_axis_tvalid <= 1'b0;
                            m01_axis_tstrb  <= '0;
                            m01_axis_tlast  <= 1'b0;
                        end else begin
                            m01_axis_tdata <= m01_axis_tdata + DATA_WIDTH'(1);
                            m01_axis_tlast <= (tx_idx + LEN_WIDTH'(2) == len_q);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_loopback_tester.sv
// tb_axis_loopback_tester
//   Drives the tester with its own m01 output looped back to s01, optionally
//   corrupting individual returned beats, and compares results with a
//   beat-list reference model.
module tb_axis_loopback_tester;

    localparam int DW = 32;
    localparam int LW = 12;
    localparam int TO = 1024;
    localparam int MAXB = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [LW-1:0]   pkt_len;
    logic [DW-1:0]   seed;
    logic [DW-1:0]   m01_tdata;
    logic [DW/8-1:0] m01_tstrb;
    logic            m01_tvalid, m01_tlast, m01_tready;
    logic [DW-1:0]   s01_tdata;
    logic [DW/8-1:0] s01_tstrb;
    logic            s01_tvalid, s01_tlast, s01_tready;
    logic            busy, done, pass, timeout;
    logic [LW-1:0]   err_count;

    int checks = 0;
    int errors = 0;

    // Loopback / corruption control
    logic            loop_en = 1'b1;
    logic            tb_ready = 1'b1;
    int              ready_mode = 0;
    int              rx_total = 0;
    int              rx_base = 0;
    int              idx;
    logic            mut_data [MAXB];
    logic [DW-1:0]   mut_val  [MAXB];
    logic            mut_strb [MAXB];
    logic [DW/8-1:0] mut_sv   [MAXB];
    logic            mut_last [MAXB];

    logic [DW+DW/8:0] tx_q [$];
    logic            hold_pending = 1'b0;
    logic [DW-1:0]   held_data;
    logic            held_last;

    initial forever #5 clk = ~clk;

    axis_loopback_tester #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
        .axis_aclk       (clk),
        .axis_reset      (reset),
        .start           (start),
        .pkt_len         (pkt_len),
        .seed            (seed),
        .m01_axis_tdata  (m01_tdata),
        .m01_axis_tstrb  (m01_tstrb),
        .m01_axis_tvalid (m01_tvalid),
        .m01_axis_tlast  (m01_tlast),
        .m01_axis_tready (m01_tready),
        .s01_axis_tdata  (s01_tdata),
        .s01_axis_tstrb  (s01_tstrb),
        .s01_axis_tvalid (s01_tvalid),
        .s01_axis_tlast  (s01_tlast),
        .s01_axis_tready (s01_tready),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .err_count       (err_count)
    );

    // Loopback wire with per-beat corruption indexed by returned-beat number
    always_comb begin
        idx        = rx_total - rx_base;
        s01_tvalid = loop_en && m01_tvalid && tb_ready;
        m01_tready = tb_ready && (loop_en ? s01_tready : 1'b1);
        s01_tdata  = m01_tdata;
        s01_tstrb  = m01_tstrb;
        s01_tlast  = m01_tlast;
        if (idx >= 0 && idx < MAXB) begin
            if (mut_data[idx]) s01_tdata = mut_val[idx];
            if (mut_strb[idx]) s01_tstrb = mut_sv[idx];
            if (mut_last[idx]) s01_tlast = !m01_tlast;
        end
    end

    always @(posedge clk) begin
        if (s01_tvalid && s01_tready) rx_total <= rx_total + 1;
    end

    // Downstream ready pattern, changed just after each rising edge
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            1:       tb_ready = !tb_ready;
            2:       tb_ready = ($urandom_range(0, 3) != 0);
            default: tb_ready = 1'b1;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // TX monitor: record accepted beats, and require a stalled beat to hold
    initial forever begin
        @(negedge clk);
        if (hold_pending && !reset) begin
            checkOutput("tx_hold_valid", 64'(m01_tvalid), 64'(1));
            checkOutput("tx_hold_data", 64'(m01_tdata), 64'(held_data));
            checkOutput("tx_hold_last", 64'(m01_tlast), 64'(held_last));
        end
        hold_pending = m01_tvalid && !m01_tready && !reset;
        held_data    = m01_tdata;
        held_last    = m01_tlast;
        if (m01_tvalid && m01_tready && !reset) tx_q.push_back({m01_tlast, m01_tstrb, m01_tdata});
    end

    task automatic clearMutations();
        for (int i = 0; i < MAXB; i++) begin
            mut_data[i] = 1'b0;
            mut_val[i]  = '0;
            mut_strb[i] = 1'b0;
            mut_sv[i]   = '0;
            mut_last[i] = 1'b0;
        end
    endtask

    // Reference: what arrives at s01 beat i is the ideal pattern unless a
    // corruption replaces it; count beats that break the packet rules.
    function automatic int modelErrors(input int len, input logic [DW-1:0] sd);
        int n;
        logic [DW-1:0]   want, d;
        logic [DW/8-1:0] s;
        logic            last_exp, l;
        n = 0;
        for (int i = 0; i < len; i++) begin
            want     = sd + DW'(i);
            last_exp = (i == len - 1);
            d = mut_data[i] ? mut_val[i] : want;
            s = mut_strb[i] ? mut_sv[i] : {(DW/8){1'b1}};
            l = mut_last[i] ? !last_exp : last_exp;
            if (d != want || s != {(DW/8){1'b1}} || l != last_exp) n++;
        end
        return n;
    endfunction

    // Issue a start and wait (bounded) for done; cyc counts negedges after start
    task automatic applyStimulus(input int len, input logic [DW-1:0] sd, input int budget, output int cyc);
        @(negedge clk);
        start   = 1'b1;
        pkt_len = LW'(len);
        seed    = sd;
        rx_base = rx_total;
        tx_q.delete();
        @(negedge clk);
        start = 1'b0;
        if (len != 0) begin
            checkOutput("first_beat_valid", 64'(m01_tvalid), 64'(1));
            checkOutput("first_beat_data", 64'(m01_tdata), 64'(sd));
            checkOutput("busy_in_run", 64'(busy), 64'(1));
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic checkRun(input string name, input int len, input logic [DW-1:0] sd,
                            input int exp_err, input logic exp_pass, input logic exp_to);
        logic [DW-1:0] want;
        checkOutput({name, "_done"}, 64'(done), 64'(1));
        checkOutput({name, "_pass"}, 64'(pass), 64'(exp_pass));
        checkOutput({name, "_err"}, 64'(err_count), 64'(exp_err));
        checkOutput({name, "_timeout"}, 64'(timeout), 64'(exp_to));
        checkOutput({name, "_txcount"}, 64'(tx_q.size()), 64'(len));
        for (int i = 0; i < len && i < tx_q.size(); i++) begin
            want = sd + DW'(i);
            checkOutput({name, "_txdata"}, 64'(tx_q[i][DW-1:0]), 64'(want));
            checkOutput({name, "_txstrb"}, 64'(tx_q[i][DW+DW/8-1:DW]), 64'({(DW/8){1'b1}}));
            checkOutput({name, "_txlast"}, 64'(tx_q[i][DW+DW/8]), 64'(i == len - 1));
        end
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, 64'(done), 64'(0));
        checkOutput({name, "_pass_held"}, 64'(pass), 64'(exp_pass));
    endtask

    initial begin
        int cyc, len, n, seen;
        logic [DW-1:0] sd;

        clearMutations();
        reset = 1'b1; start = 1'b0; pkt_len = '0; seed = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_tvalid", 64'(m01_tvalid), 64'(0));
        checkOutput("rst_tdata", 64'(m01_tdata), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_pass", 64'(pass), 64'(0));
        checkOutput("rst_timeout", 64'(timeout), 64'(0));
        checkOutput("rst_err", 64'(err_count), 64'(0));
        checkOutput("rst_rx_ready", 64'(s01_tready), 64'(0));
        reset = 1'b0;

        $display("[TB] test 1: basic loopback");
        applyStimulus(3, 32'h55, 100, cyc);
        checkRun("t1", 3, 32'h55, 0, 1'b1, 1'b0);

        $display("[TB] test 2: toggling tready");
        ready_mode = 1;
        applyStimulus(4, 32'h22, 100, cyc);
        checkRun("t2", 4, 32'h22, 0, 1'b1, 1'b0);
        ready_mode = 0;

        $display("[TB] test 3: corrupted data beat");
        clearMutations();
        mut_data[1] = 1'b1; mut_val[1] = 32'h99;
        applyStimulus(3, 32'h24, 100, cyc);
        checkRun("t3", 3, 32'h24, 1, 1'b0, 1'b0);

        $display("[TB] test 4: misplaced tlast");
        clearMutations();
        mut_last[2] = 1'b1; mut_last[3] = 1'b1;
        applyStimulus(4, 32'h1000, 100, cyc);
        checkRun("t4", 4, 32'h1000, 2, 1'b0, 1'b0);
        clearMutations();

        $display("[TB] test 5: no returned data");
        loop_en = 1'b0;
        applyStimulus(2, 32'h77, 2000, cyc);
        checkOutput("t5_timeout_cycles", 64'(cyc), 64'(TO));
        checkRun("t5", 2, 32'h77, 0, 1'b0, 1'b1);
        loop_en = 1'b1;

        $display("[TB] test 6: reset mid-run");
        @(negedge clk);
        start = 1'b1; pkt_len = LW'(8); seed = 32'h300; rx_base = rx_total;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while ((rx_total - rx_base) < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t6_reached_beat3", 64'(rx_total - rx_base), 64'(3));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_tvalid", 64'(m01_tvalid), 64'(0));
        checkOutput("t6_busy", 64'(busy), 64'(0));
        checkOutput("t6_done", 64'(done), 64'(0));
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        checkOutput("t6_no_done", 64'(seen), 64'(0));
        sd = $urandom;
        applyStimulus(1, sd, 100, cyc);
        checkRun("t6_fresh", 1, sd, 0, 1'b1, 1'b0);

        $display("[TB] test 7: data wrap and zero length");
        applyStimulus(2, 32'hFFFF_FFFF, 100, cyc);
        checkRun("t7_wrap", 2, 32'hFFFF_FFFF, 0, 1'b1, 1'b0);
        applyStimulus(0, 32'h5, 10, cyc);
        checkOutput("t7_len0_busy", 64'(busy), 64'(0));
        checkRun("t7_len0", 0, 32'h5, 0, 1'b0, 1'b0);

        $display("[TB] random runs");
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            clearMutations();
            len = $urandom_range(1, 12);
            sd  = $urandom;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0: begin mut_data[i] = 1'b1; mut_val[i] = $urandom; end
                        1: begin mut_strb[i] = 1'b1; mut_sv[i] = 4'($urandom_range(0, 14)); end
                        default: mut_last[i] = 1'b1;
                    endcase
                end
            end
            n = modelErrors(len, sd);
            applyStimulus(len, sd, 500, cyc);
            checkRun("rand", len, sd, n, (n == 0), 1'b0);
        end
        ready_mode = 0;
        clearMutations();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
